// File: rtl/hubris_pkg.sv
// ============================================================================
// Module : hubris_pkg
// Brief  : Shared write-width constants, response tag type and flush helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hubris_pkg;

  localparam logic [3:0] c_WIDTH_BYTE = 4'd1;
  localparam logic [3:0] c_WIDTH_HALF = 4'd2;
  localparam logic [3:0] c_WIDTH_WORD = 4'd4;

  typedef struct packed {
    logic valid;
    logic is_inst;
  } arb_tag_t;

  // An inst flush kills the tag's response but keeps its slot in the pipe.
  function automatic arb_tag_t flush_tag(input arb_tag_t tag, input logic flush_inst);
    flush_tag = tag;
    if (flush_inst && tag.is_inst) flush_tag.valid = 1'b0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_tag_pipe.sv
// ============================================================================
// Module : arb_tag_pipe
// Brief  : DEPTH-stage shift register of response tags with inst flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_tag_pipe
  import hubris_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush_inst,
  input  arb_tag_t in_tag,
  output arb_tag_t out_tag
);

  arb_tag_t r_stage [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= flush_tag(in_tag, flush_inst);
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= flush_tag(r_stage[i-1], flush_inst);
    end
  end

  // The exiting tag is still in flight this cycle, so a flush suppresses it too.
  assign out_tag = flush_tag(r_stage[DEPTH-1], flush_inst);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Inst/data arbiter onto one shared memory port, data-first priority.
//          Define ARB_STARVE_GUARD_EN to enable the inst starvation guard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import hubris_pkg::*;
#(
  parameter int WORD_WIDTH_IN_BIT = 32,
  parameter int MEM_LATENCY       = 1,
  parameter int STARVE_LIMIT      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         inst_req_valid,
  output logic                         inst_req_ready,
  input  logic [WORD_WIDTH_IN_BIT-1:0] inst_addr,
  input  logic                         inst_flush,
  output logic                         inst_resp_valid,
  output logic [WORD_WIDTH_IN_BIT-1:0] inst_resp_data,
  input  logic                         data_req_valid,
  output logic                         data_req_ready,
  input  logic [WORD_WIDTH_IN_BIT-1:0] data_addr,
  input  logic                         data_write_en,
  input  logic [3:0]                   data_write_width,
  input  logic [WORD_WIDTH_IN_BIT-1:0] data_write_data,
  output logic                         data_resp_valid,
  output logic [WORD_WIDTH_IN_BIT-1:0] data_resp_data,
  output logic                         mem_req_valid,
  output logic [WORD_WIDTH_IN_BIT-1:0] mem_addr,
  output logic                         mem_write_en,
  output logic [3:0]                   mem_write_width,
  output logic [WORD_WIDTH_IN_BIT-1:0] mem_write_data,
  input  logic [WORD_WIDTH_IN_BIT-1:0] mem_read_data
);

  logic     w_grant_inst;
  logic     w_grant_data;
  logic     w_starve_win;
  arb_tag_t w_in_tag;
  arb_tag_t w_out_tag;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] r_starve_cnt;

  assign w_starve_win = (r_starve_cnt >= 4'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant_inst) begin
      r_starve_cnt <= 4'd0;
    end else if (inst_req_valid && r_starve_cnt != 4'hF) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`else
  assign w_starve_win = 1'b0;
`endif

  // Ready is gated by reset so nothing is accepted while reset is asserted.
  assign w_grant_data   = reset && data_req_valid && !(inst_req_valid && w_starve_win);
  assign w_grant_inst   = reset && inst_req_valid && !w_grant_data;
  assign data_req_ready = w_grant_data;
  assign inst_req_ready = w_grant_inst;

  always_comb begin
    mem_req_valid   = w_grant_inst || w_grant_data;
    mem_addr        = '0;
    mem_write_en    = 1'b0;
    mem_write_width = 4'd0;
    mem_write_data  = '0;
    if (w_grant_data) begin
      mem_addr        = data_addr;
      mem_write_en    = data_write_en;
      mem_write_width = data_write_width;
      mem_write_data  = data_write_data;
    end else if (w_grant_inst) begin
      mem_addr        = inst_addr;
      mem_write_width = c_WIDTH_WORD;
    end
  end

  assign w_in_tag.valid   = w_grant_inst || (w_grant_data && !data_write_en);
  assign w_in_tag.is_inst = w_grant_inst;

  arb_tag_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .flush_inst (inst_flush),
    .in_tag     (w_in_tag),
    .out_tag    (w_out_tag)
  );

  assign inst_resp_valid = w_out_tag.valid &&  w_out_tag.is_inst;
  assign data_resp_valid = w_out_tag.valid && !w_out_tag.is_inst;
  assign inst_resp_data  = mem_read_data;
  assign data_resp_data  = mem_read_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Scoreboard bench for mem_port_arbiter (honours ARB_STARVE_GUARD_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int W     = 32;
  localparam int LAT   = 3;
  localparam int LIMIT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         inst_req_valid, inst_req_ready, inst_flush, inst_resp_valid;
  logic [W-1:0] inst_addr, inst_resp_data;
  logic         data_req_valid, data_req_ready, data_write_en, data_resp_valid;
  logic [3:0]   data_write_width;
  logic [W-1:0] data_addr, data_write_data, data_resp_data;
  logic         mem_req_valid, mem_write_en;
  logic [3:0]   mem_write_width;
  logic [W-1:0] mem_addr, mem_write_data, mem_read_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .WORD_WIDTH_IN_BIT (W),
    .MEM_LATENCY       (LAT),
    .STARVE_LIMIT      (LIMIT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .inst_req_valid   (inst_req_valid),
    .inst_req_ready   (inst_req_ready),
    .inst_addr        (inst_addr),
    .inst_flush       (inst_flush),
    .inst_resp_valid  (inst_resp_valid),
    .inst_resp_data   (inst_resp_data),
    .data_req_valid   (data_req_valid),
    .data_req_ready   (data_req_ready),
    .data_addr        (data_addr),
    .data_write_en    (data_write_en),
    .data_write_width (data_write_width),
    .data_write_data  (data_write_data),
    .data_resp_valid  (data_resp_valid),
    .data_resp_data   (data_resp_data),
    .mem_req_valid    (mem_req_valid),
    .mem_addr         (mem_addr),
    .mem_write_en     (mem_write_en),
    .mem_write_width  (mem_write_width),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  function automatic logic [W-1:0] memf(input logic [W-1:0] a);
    memf = {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // Memory model: read data appears exactly LAT cycles after the request.
  logic [W-1:0] r_mem_addr [LAT];
  always @(posedge clk) begin
    r_mem_addr[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) r_mem_addr[i] <= r_mem_addr[i-1];
  end
  assign mem_read_data = memf(r_mem_addr[LAT-1]);

  typedef struct {
    int           due;
    bit           is_inst;
    logic [W-1:0] data;
    bit           live;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   mstarve = 0;
  int   n_iresp = 0, n_dresp = 0, n_igrant = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit           gi, gd, starve_win, ev_i, ev_d;
    logic [W-1:0] ed;
    exp_t         e;
    cyc++;
    if (inst_resp_valid) n_iresp++;
    if (data_resp_valid) n_dresp++;
    if (inst_req_ready)  n_igrant++;
    if (!reset) begin
      chk("rst_inst_ready", inst_req_ready, 0);
      chk("rst_data_ready", data_req_ready, 0);
      chk("rst_mem_valid", mem_req_valid, 0);
      chk("rst_inst_resp", inst_resp_valid, 0);
      chk("rst_data_resp", data_resp_valid, 0);
      q.delete();
      mstarve = 0;
    end else begin
`ifdef ARB_STARVE_GUARD_EN
      starve_win = (mstarve >= LIMIT);
`else
      starve_win = 1'b0;
`endif
      gd = data_req_valid && !(inst_req_valid && starve_win);
      gi = inst_req_valid && !gd;
      chk("inst_ready", inst_req_ready, gi);
      chk("data_ready", data_req_ready, gd);
      chk("mem_valid", mem_req_valid, gi || gd);
      chk("mem_we", mem_write_en, gd && data_write_en);
      if (gd) begin
        chk("mem_addr_d", mem_addr, data_addr);
        chk("mem_width_d", mem_write_width, data_write_width);
        if (data_write_en) chk("mem_wdata", mem_write_data, data_write_data);
      end else if (gi) begin
        chk("mem_addr_i", mem_addr, inst_addr);
        chk("mem_width_i", mem_write_width, 4);
      end
      if (inst_flush) foreach (q[k]) if (q[k].is_inst) q[k].live = 0;
      ev_i = 0; ev_d = 0; ed = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (e.live) begin
          ev_i = e.is_inst;
          ev_d = !e.is_inst;
          ed   = e.data;
        end
      end
      chk("inst_resp_valid", inst_resp_valid, ev_i);
      chk("data_resp_valid", data_resp_valid, ev_d);
      if (ev_i) chk("inst_resp_data", inst_resp_data, ed);
      if (ev_d) chk("data_resp_data", data_resp_data, ed);
      if (gi) q.push_back('{cyc + LAT, 1'b1, memf(inst_addr), !inst_flush});
      if (gd && !data_write_en) q.push_back('{cyc + LAT, 1'b0, memf(data_addr), 1'b1});
      if (gi) mstarve = 0;
      else if (inst_req_valid && mstarve < 15) mstarve++;
    end
  end

  task automatic drv(input bit iv, input logic [W-1:0] ia, input bit dv,
                     input logic [W-1:0] da, input bit we, input logic [3:0] ww,
                     input logic [W-1:0] wd, input bit fl);
    inst_req_valid   = iv;
    inst_addr        = ia;
    data_req_valid   = dv;
    data_addr        = da;
    data_write_en    = we;
    data_write_width = ww;
    data_write_data  = wd;
    inst_flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, '0, 0, '0, 0, 4'd0, '0, 0);
  endtask

  initial begin
    int         si, sd, sg;
    logic [3:0] widths [3];
    widths[0] = 4'd1; widths[1] = 4'd2; widths[2] = 4'd4;
    reset = 1'b0;
    inst_req_valid = 0; inst_addr = '0; inst_flush = 0;
    data_req_valid = 0; data_addr = '0; data_write_en = 0;
    data_write_width = 4'd0; data_write_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    drv(1, 32'h100, 0, '0, 0, 4'd0, '0, 0);
    idle(LAT + 1);
    drv(1, 32'h104, 1, 32'h2000, 0, 4'd4, '0, 0);
    idle(LAT + 1);
    drv(0, '0, 1, 32'h3000, 1, 4'd4, 32'hDEADBEEF, 0);
    idle(LAT + 1);

    si = n_iresp; sd = n_dresp;
    drv(0, '0, 1, 32'h2004, 0, 4'd4, '0, 0);
    drv(1, 32'h200, 0, '0, 0, 4'd0, '0, 0);
    drv(1, 32'h204, 0, '0, 0, 4'd0, '0, 0);
    drv(1, 32'h208, 0, '0, 0, 4'd0, '0, 1);
    idle(LAT + 2);
    chk("flush_inst_resp_cnt", n_iresp - si, 0);
    chk("flush_data_resp_cnt", n_dresp - sd, 1);

    drv(1, 32'h300, 0, '0, 0, 4'd0, '0, 0);
    drv(0, '0, 1, 32'h4000, 0, 4'd4, '0, 0);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    si = n_iresp; sd = n_dresp;
    idle(3);
    chk("rst_quiet_resp_cnt", (n_iresp - si) + (n_dresp - sd), 0);
    drv(1, 32'h400, 0, '0, 0, 4'd0, '0, 0);
    idle(LAT + 1);
    chk("post_rst_inst_resp_cnt", n_iresp - si, 1);

    sg = n_igrant;
    for (int i = 0; i < 10; i++) drv(1, 32'h500 + 4 * i, 1, 32'h6000 + 4 * i, 0, 4'd4, '0, 0);
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_inst_grants", n_igrant - sg, 2);
`else
    chk("starve_inst_grants", n_igrant - sg, 0);
`endif
    idle(LAT + 1);

    for (int i = 0; i < 300; i++)
      drv($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom,
          $urandom_range(0, 1), widths[$urandom_range(0, 2)], $urandom,
          ($urandom_range(0, 7) == 0));
    idle(LAT + 2);
    chk("sb_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
